// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Decodes {funct5, rm} of an OP-FP instruction and sequences it towards the
// FPU datapath. The decoded fields are registered when an op is accepted.
// The op then completes after a latency that depends on its class: add/sub/cvt,
// mul, div/sqrt, or single-cycle for everything else.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   flush              synchronous kill of the in-flight/pending op
//   in_valid/in_ready  request handshake (in_ready is combinational)
//   funct5, rm, frm    instruction fields; frm replaces rm when rm = 3'b111
//   out_valid/out_ready result handshake
//   sel, FPUAinSel     registered FPU select and A-input mux control
//   rm_eff, illegal    registered rounding mode and illegal-encoding flag
//   busy               an op is counting down its latency
//
// state | meaning
// IDLE  | no op held, ready to accept
// BUSY  | op accepted, latency counter running
// DONE  | result fields valid, waiting for out_ready
module fpu_issue_ctrl #(
    parameter int SEL_W   = 5,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 12,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       funct5,
    input  logic [2:0]       rm,
    input  logic [2:0]       frm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             FPUAinSel,
    output logic [2:0]       rm_eff,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {CLS_ONE, CLS_ADD, CLS_MUL, CLS_DIV} cls_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             ain_q, ain_d;
    logic [2:0]       rm_eff_q, rm_eff_d;
    logic             illegal_q, illegal_d;

    logic [4:0]       dec_sel;
    logic             dec_ain;
    logic             dec_ill;
    cls_t             dec_cls;
    logic [2:0]       dec_rm;
    logic [2:0]       rm_res;
    logic [CNT_W-1:0] dec_lat_m1;
    logic             accept;

    always_comb begin
        dec_sel = 5'd0;
        dec_ain = 1'b0;
        dec_ill = 1'b0;
        dec_cls = CLS_ONE;
        casez ({funct5, rm})
            8'b00000_???: begin dec_sel = 5'd4;  dec_cls = CLS_ADD; end
            8'b00001_???: begin dec_sel = 5'd5;  dec_cls = CLS_ADD; end
            8'b00010_???: begin dec_sel = 5'd6;  dec_cls = CLS_MUL; end
            8'b00011_???: begin dec_sel = 5'd16; dec_cls = CLS_DIV; end
            8'b01011_???: begin dec_sel = 5'd17; dec_cls = CLS_DIV; end
            8'b00101_000: dec_sel = 5'd7;
            8'b00101_001: dec_sel = 5'd8;
            8'b10100_010: dec_sel = 5'd9;
            8'b10100_001: dec_sel = 5'd10;
            8'b10100_000: dec_sel = 5'd11;
            8'b11110_???: begin dec_sel = 5'd12; dec_ain = 1'b1; end
            8'b11100_000: dec_sel = 5'd13;
            8'b11010_???: begin dec_sel = 5'd14; dec_ain = 1'b1; dec_cls = CLS_ADD; end
            8'b11000_???: begin dec_sel = 5'd15; dec_cls = CLS_ADD; end
            8'b00100_000: dec_sel = 5'd18;
            8'b00100_001: dec_sel = 5'd19;
            8'b00100_010: dec_sel = 5'd20;
            default:      dec_ill = 1'b1;
        endcase

        // Only the rounding classes see the dynamic mode; a reserved resolved
        // mode turns the op into a single-cycle illegal result.
        rm_res = (rm == 3'b111) ? frm : rm;
        dec_rm = rm;
        if (dec_cls != CLS_ONE) begin
            dec_rm = rm_res;
            if (rm_res == 3'b101 || rm_res == 3'b110) begin
                dec_ill = 1'b1;
                dec_sel = 5'd0;
                dec_ain = 1'b0;
                dec_cls = CLS_ONE;
            end
        end

        case (dec_cls)
            CLS_ADD: dec_lat_m1 = CNT_W'(ADD_LAT - 1);
            CLS_MUL: dec_lat_m1 = CNT_W'(MUL_LAT - 1);
            CLS_DIV: dec_lat_m1 = CNT_W'(DIV_LAT - 1);
            default: dec_lat_m1 = '0;
        endcase
    end

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        ain_d     = ain_q;
        rm_eff_d  = rm_eff_q;
        illegal_d = illegal_q;

        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: ;
        endcase

        // accept can only happen in IDLE or DONE&out_ready, so it overrides
        // the plain transitions above (zero-bubble back-to-back).
        if (accept) begin
            sel_d     = SEL_W'(dec_sel);
            ain_d     = dec_ain;
            rm_eff_d  = dec_rm;
            illegal_d = dec_ill;
            cnt_d     = dec_lat_m1;
            state_d   = (dec_lat_m1 == '0) ? DONE : BUSY;
        end

        // Registered fields are deliberately left holding on a flush.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            ain_q     <= 1'b0;
            rm_eff_q  <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ain_q     <= ain_d;
            rm_eff_q  <= rm_eff_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign sel       = sel_q;
    assign FPUAinSel = ain_q;
    assign rm_eff    = rm_eff_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam int SEL_W   = 5;
    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       funct5;
    logic [2:0]       rm;
    logic [2:0]       frm;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic             FPUAinSel;
    logic [2:0]       rm_eff;
    logic             illegal;
    logic             busy;

    int tests = 0;
    int fails = 0;

    fpu_issue_ctrl #(
        .SEL_W(SEL_W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct5(funct5), .rm(rm), .frm(frm),
        .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .FPUAinSel(FPUAinSel), .rm_eff(rm_eff),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] sel;
        logic       ain;
        logic [2:0] rm;
        logic       ill;
        int         lat;
    } op_t;

    // Reference: spec table looked up per funct5, then rounding resolution.
    function automatic op_t ref_decode(logic [4:0] f, logic [2:0] r, logic [2:0] fr);
        op_t o;
        bit  ok;
        bit  rounds;
        logic [2:0] res;
        o = '0;
        o.rm = r;
        o.lat = 1;
        ok = 1;
        rounds = 0;
        case (f)
            5'd0:  begin o.sel = 4;  o.lat = ADD_LAT; rounds = 1; end
            5'd1:  begin o.sel = 5;  o.lat = ADD_LAT; rounds = 1; end
            5'd2:  begin o.sel = 6;  o.lat = MUL_LAT; rounds = 1; end
            5'd3:  begin o.sel = 16; o.lat = DIV_LAT; rounds = 1; end
            5'd11: begin o.sel = 17; o.lat = DIV_LAT; rounds = 1; end
            5'd26: begin o.sel = 14; o.ain = 1; o.lat = ADD_LAT; rounds = 1; end
            5'd24: begin o.sel = 15; o.lat = ADD_LAT; rounds = 1; end
            5'd30: begin o.sel = 12; o.ain = 1; end
            5'd28: if (r == 0) o.sel = 13; else ok = 0;
            5'd5:  if (r == 0) o.sel = 7; else if (r == 1) o.sel = 8; else ok = 0;
            5'd20: if (r == 2) o.sel = 9; else if (r == 1) o.sel = 10;
                   else if (r == 0) o.sel = 11; else ok = 0;
            5'd4:  if (r <= 2) o.sel = 5'(18 + int'(r)); else ok = 0;
            default: ok = 0;
        endcase
        if (rounds) begin
            res = (r == 3'd7) ? fr : r;
            o.rm = res;
            if (res == 3'd5 || res == 3'd6) ok = 0;
        end
        if (!ok) begin
            o.sel = 0; o.ain = 0; o.ill = 1; o.lat = 1;
        end
        return o;
    endfunction

    // Transaction-level model: an op held since accept cycle, completing at done_cyc.
    longint cyc = 0;
    bit     m_active = 0;
    longint m_done_cyc = 0;
    op_t    m_fields = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit e_busy, e_ov, e_ir, acc;
        op_t d;
        @(negedge clk);
        e_busy = m_active && (cyc < m_done_cyc);
        e_ov   = m_active && (cyc >= m_done_cyc);
        e_ir   = !m_active || (e_ov && out_ready);
        chk("in_ready",  32'(in_ready),  32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("sel",       32'(sel),       32'(m_fields.sel));
        chk("ainsel",    32'(FPUAinSel), 32'(m_fields.ain));
        chk("rm_eff",    32'(rm_eff),    32'(m_fields.rm));
        chk("illegal",   32'(illegal),   32'(m_fields.ill));
        acc = in_valid && e_ir && !flush;
        d = ref_decode(funct5, rm, frm);
        @(posedge clk);
        if (flush) begin
            m_active = 0;
        end else if (acc) begin
            m_active = 1;
            m_fields = d;
            m_done_cyc = cyc + d.lat;
        end else if (e_ov && out_ready) begin
            m_active = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic set_op(logic [4:0] f, logic [2:0] r, logic [2:0] fr);
        funct5 = f; rm = r; frm = fr;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        funct5 = 0; rm = 0; frm = 0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // idle after reset
        repeat (5) step();

        // fadd, out_ready high
        out_ready = 1; set_op(5'b00000, 3'b000, 3'b000); in_valid = 1;
        step();
        in_valid = 0;
        chk("fadd_busy_t1", 32'(busy), 32'd1);
        step();
        chk("fadd_ov_t2", 32'(out_valid), 32'd1);
        chk("fadd_sel", 32'(sel), 32'd4);
        step();
        chk("fadd_idle_t3", 32'(out_valid | busy), 32'd0);
        step();

        // fdiv with dynamic rounding, result held for a while
        out_ready = 0; set_op(5'b00011, 3'b111, 3'b011); in_valid = 1;
        step();
        in_valid = 0;
        repeat (DIV_LAT + 3) step();
        chk("fdiv_sel", 32'(sel), 32'd16);
        chk("fdiv_rm", 32'(rm_eff), 32'd3);
        out_ready = 1;
        repeat (2) step();

        // back-to-back single-cycle ops
        set_op(5'b11110, 3'b000, 3'b000); in_valid = 1;
        step();
        chk("b2b_sel1", 32'(sel), 32'd12);
        chk("b2b_ain1", 32'(FPUAinSel), 32'd1);
        set_op(5'b10100, 3'b010, 3'b000);
        step();
        chk("b2b_ov2", 32'(out_valid), 32'd1);
        chk("b2b_sel2", 32'(sel), 32'd9);
        chk("b2b_ain2", 32'(FPUAinSel), 32'd0);
        in_valid = 0;
        repeat (2) step();

        // illegal encodings
        set_op(5'b10100, 3'b011, 3'b000); in_valid = 1;
        step();
        chk("ill_enc", 32'(illegal), 32'd1);
        set_op(5'b00010, 3'b111, 3'b101);
        step();
        chk("ill_rm", 32'(illegal), 32'd1);
        chk("ill_rm_sel", 32'(sel), 32'd0);
        in_valid = 0;
        repeat (2) step();

        // fsqrt flushed at its 4th cycle, with a competing request
        set_op(5'b01011, 3'b000, 3'b000); in_valid = 1;
        step();
        in_valid = 0;
        repeat (3) step();
        flush = 1; in_valid = 1; set_op(5'b00000, 3'b000, 3'b000);
        step();
        flush = 0; in_valid = 0;
        chk("flush_idle", 32'(busy | out_valid), 32'd0);
        repeat (DIV_LAT + 2) step();

        // async reset in the middle of a divide
        set_op(5'b00011, 3'b001, 3'b000); in_valid = 1;
        step();
        in_valid = 0;
        repeat (3) step();
        #2 reset = 1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_rm", 32'(rm_eff), 32'd0);
        m_active = 0; m_fields = '0;
        @(posedge clk);
        #1 reset = 0;
        repeat (2) step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] ops [12];
            ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd5, 5'd20, 5'd30, 5'd28, 5'd26, 5'd24, 5'd4};
            if ($urandom_range(0, 15) < 12)
                funct5 = ops[$urandom_range(0, 11)];
            else
                funct5 = 5'($urandom);
            rm        = 3'($urandom);
            frm       = 3'($urandom);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
